bin2bcd_seq: RTL

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
- Sits downstream of the interpolation/lookup result register and upstream of SS_Driver.
- Takes the 14-bit y result and produces per-digit codes for the seven-segment digit inputs.
- Replaces the divide/multiply digit extraction in the display path with a fixed-latency, timing-friendly engine with a start/done handshake.

---
 rtl/bin2bcd_pkg.sv | 28 ++
 rtl/bcd_add3.sv | 10 +
 rtl/bin2bcd_seq.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// state encoding, default blank digit code and the saturation limit helper.
package bin2bcd_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

    // Code the seven-segment driver renders as an unlit digit.
    localparam logic [4:0] BLANK_CODE_DEFAULT = 5'h1F;

    // Largest value representable in n decimal digits, i.e. 10^n - 1.
    function automatic int unsigned sat_limit(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned k = 0; k < n; k++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: adds 3 to any BCD nibble of 5 or more so
// that the following left shift carries correctly into the next decade.
module bcd_add3 (
    input  logic [3:0] nibble,
    output logic [3:0] corrected
);

    assign corrected = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one iteration per
// clock, with a start/busy/done handshake. Inputs above 10^N_DIGITS-1 are
// saturated and flagged as overflow.
// Optional macro BIN2BCD_BLANK_LEADING_EN: replace leading zero digits
// (never digit0) with BLANK_CODE in the registered result.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int                 IN_W       = 14,
    parameter int                 N_DIGITS   = 4,
    parameter int                 DIGIT_W    = 5,
    parameter logic [DIGIT_W-1:0] BLANK_CODE = DIGIT_W'(BLANK_CODE_DEFAULT)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [IN_W-1:0]               bin,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic [N_DIGITS*DIGIT_W-1:0]   digits
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam logic [IN_W-1:0]  SAT_VAL   = IN_W'(sat_limit(N_DIGITS));
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_W - 1);

`ifdef BIN2BCD_BLANK_LEADING_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    state_t                      state;
    state_t                      state_next;
    logic [IN_W-1:0]             shift_bin;
    logic [IN_W-1:0]             bin_next;
    logic [BCD_W-1:0]            bcd;
    logic [BCD_W-1:0]            bcd_adj;
    logic [BCD_W-1:0]            bcd_next;
    logic [CNT_W-1:0]            cnt;
    logic                        ovf_pend;
    logic                        carry_lost;
    logic                        in_over;
    logic [N_DIGITS*DIGIT_W-1:0] digits_fmt;
    logic                        blank_run;
    logic [3:0]                  nibble;

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nibble   (bcd[4*g +: 4]),
            .corrected(bcd_adj[4*g +: 4])
        );
    end

    // A bit pushed out of the top nibble would mean the value did not fit;
    // saturation prevents it, but it is folded into overflow rather than lost.
    assign carry_lost = bcd_adj[BCD_W-1];
    assign bcd_next   = {bcd_adj[BCD_W-2:0], shift_bin[IN_W-1]};
    assign bin_next   = {shift_bin[IN_W-2:0], 1'b0};
    assign in_over    = (bin > SAT_VAL);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start is honoured only in IDLE, DONE always lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == LAST_ITER) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Format the final BCD into digit codes, optionally blanking leading zeros
    // from the most significant digit down to the first nonzero one.
    always_comb begin
        digits_fmt = '0;
        blank_run  = BLANK_EN;
        nibble     = 4'd0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            nibble = bcd_next[4*i +: 4];
            if (blank_run && (i != 0) && (nibble == 4'd0)) begin
                digits_fmt[i*DIGIT_W +: DIGIT_W] = BLANK_CODE;
            end else begin
                digits_fmt[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(nibble);
                blank_run = 1'b0;
            end
        end
    end

    // Capture, shift iterations and result register; the outputs are only
    // reloaded on the last shift so they hold steady during a conversion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_bin <= '0;
            bcd       <= '0;
            cnt       <= '0;
            ovf_pend  <= 1'b0;
            digits    <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_bin <= in_over ? SAT_VAL : bin;
                        ovf_pend  <= in_over;
                        bcd       <= '0;
                        cnt       <= '0;
                    end
                end
                SHIFT: begin
                    bcd       <= bcd_next;
                    shift_bin <= bin_next;
                    cnt       <= cnt + CNT_W'(1);
                    ovf_pend  <= ovf_pend | carry_lost;
                    if (cnt == LAST_ITER) begin
                        digits   <= digits_fmt;
                        overflow <= ovf_pend | carry_lost;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
